wave_capture_buf: RTL and testbench

- Triggered, decimated sample capture with ping-pong (double) buffering.
- Sits between the waveform-select mux output (the sample also fed to the PWM) and the VGA renderer.
- Captures one screen width of samples starting at a rising zero crossing, then swaps banks so the VGA reads a stable, tear-free frame.

---
 rtl/wave_cap_pkg.sv | 14 +
 rtl/wave_cap_dpram.sv | 24 ++
 rtl/wave_capture_buf.sv | 170 +++++++++++++++++
 tb/tb_wave_capture_buf.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_cap_pkg.sv
// Shared types and constants for the triggered ping-pong waveform capture buffer.
package wave_cap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_TRIG = 2'd1,
      ST_CAPTURE   = 2'd2,
      ST_HOLD      = 2'd3
   } cap_state_t;

   // Autotrigger timeout, in frames' worth of decimated samples.
   localparam int AUTOTRIG_MULT = 4;

endpackage

// File: rtl/wave_cap_dpram.sv
// Simple dual-port RAM holding both capture banks; address is {bank, column}.
module wave_cap_dpram #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W:0]   i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic [ADDR_W:0]   i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [0:(2**(ADDR_W+1))-1];

   // No reset on the array or read register so the tools map this onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/wave_capture_buf.sv
// Triggered, decimated one-frame sample capture with ping-pong banks for the VGA renderer.
// Optional build macro WAVE_CAP_AUTOTRIG_EN forces a capture after a long wait without a zero crossing.
module wave_capture_buf
   import wave_cap_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 640,
   parameter int ADDR_W  = 10,
   parameter int DECIM_W = 16
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic signed [WIDTH-1:0]  sample_in,
   input  logic                     sample_valid,
   input  logic [DECIM_W-1:0]       decim,
   input  logic                     arm,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     disp_bank,
   output logic [1:0]               o_dbg_state
);

   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   cap_state_t          r_state;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic                r_disp_bank;
   logic                r_busy;
   logic                r_frame_done;
   logic [DECIM_W-1:0]  r_dcnt;
   logic [DECIM_W-1:0]  r_dmax;
   logic                r_prev_neg;
   logic                r_rd_ok;

   logic [DECIM_W-1:0]  w_dmax_live;
   logic [DECIM_W-1:0]  w_dmax;
   logic                w_dstb;
   logic                w_trig;
   logic                w_auto_go;
   logic                w_start;
   logic                w_cap_wr;
   logic                w_last;
   logic                w_we;
   logic [WIDTH-1:0]    w_ram_q;

   // The terminal count is sampled at the start of each decimation period,
   // so a change to decim only takes hold after the current period wraps.
   assign w_dmax_live = (decim == '0) ? '0 : decim - DECIM_W'(1);
   assign w_dmax      = (r_dcnt == '0) ? w_dmax_live : r_dmax;
   assign w_dstb      = sample_valid && (r_dcnt == w_dmax);
   assign w_trig      = w_dstb && r_prev_neg && !sample_in[WIDTH-1];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_dcnt     <= '0;
         r_dmax     <= '0;
         r_prev_neg <= 1'b0;
      end else if (sample_valid) begin
         if (r_dcnt == '0) begin
            r_dmax <= w_dmax_live;
         end
         if (w_dstb) begin
            r_dcnt     <= '0;
            r_prev_neg <= sample_in[WIDTH-1];
         end else begin
            r_dcnt <= r_dcnt + DECIM_W'(1);
         end
      end
   end

`ifdef WAVE_CAP_AUTOTRIG_EN
   localparam int AUTO_LIMIT = AUTOTRIG_MULT * DEPTH;
   localparam int AUTO_W     = $clog2(AUTO_LIMIT + 1);

   logic [AUTO_W-1:0] r_auto_cnt;

   assign w_auto_go = w_dstb && (r_auto_cnt == AUTO_W'(AUTO_LIMIT - 1));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_auto_cnt <= '0;
      end else if (r_state != ST_WAIT_TRIG) begin
         r_auto_cnt <= '0;
      end else if (w_dstb) begin
         r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
      end
   end
`else
   assign w_auto_go = 1'b0;
`endif

   assign w_start  = (r_state == ST_WAIT_TRIG) && (w_trig || w_auto_go);
   assign w_cap_wr = (r_state == ST_CAPTURE) && w_dstb;
   assign w_last   = w_cap_wr && (r_wr_ptr == LAST_PTR);
   assign w_we     = w_start || w_cap_wr;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_wr_ptr     <= '0;
         r_disp_bank  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_HOLD: begin
               if (arm) begin
                  r_state  <= ST_WAIT_TRIG;
                  r_wr_ptr <= '0;
                  r_busy   <= 1'b1;
               end
            end
            ST_WAIT_TRIG: begin
               if (w_start) begin
                  r_state  <= ST_CAPTURE;
                  r_wr_ptr <= ADDR_W'(1);
               end
            end
            ST_CAPTURE: begin
               // Final column written: swap banks and stop until re-armed.
               if (w_last) begin
                  r_state      <= ST_HOLD;
                  r_frame_done <= 1'b1;
                  r_disp_bank  <= ~r_disp_bank;
                  r_busy       <= 1'b0;
               end else if (w_cap_wr) begin
                  r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Write bank is always the complement of the display bank.
   wave_cap_dpram #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk   (clock),
      .i_we    (w_we),
      .i_waddr ({~r_disp_bank, r_wr_ptr}),
      .i_wdata (sample_in),
      .i_raddr ({r_disp_bank, rd_addr}),
      .o_rdata (w_ram_q)
   );

   // Out-of-frame columns and the post-reset read return zero without resetting the RAM.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_rd_ok <= 1'b0;
      end else begin
         r_rd_ok <= ({1'b0, rd_addr} < DEPTH_X);
      end
   end

   assign rd_data     = r_rd_ok ? w_ram_q : '0;
   assign busy        = r_busy;
   assign frame_done  = r_frame_done;
   assign disp_bank   = r_disp_bank;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wave_capture_buf.sv
// Randomized bench for wave_capture_buf against a queue-based frame capture model.
module tb_wave_capture_buf;

   localparam int WIDTH   = 16;
   localparam int DEPTH   = 640;
   localparam int ADDR_W  = 10;
   localparam int DECIM_W = 16;
`ifdef WAVE_CAP_AUTOTRIG_EN
   localparam bit AUTO_EN = 1'b1;
`else
   localparam bit AUTO_EN = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic                     clock = 1'b0;
   logic                     resetn = 1'b0;
   logic signed [WIDTH-1:0]  sample_in = '0;
   logic                     sample_valid = 1'b0;
   logic [DECIM_W-1:0]       decim = DECIM_W'(1);
   logic                     arm = 1'b0;
   logic [ADDR_W-1:0]        rd_addr = '0;
   logic [WIDTH-1:0]         rd_data;
   logic                     busy;
   logic                     frame_done;
   logic                     disp_bank;
   logic [1:0]               dbg_state;

   always #5 clock = ~clock;

   wave_capture_buf #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .DECIM_W (DECIM_W)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .decim        (decim),
      .arm          (arm),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .frame_done   (frame_done),
      .disp_bank    (disp_bank),
      .o_dbg_state  (dbg_state)
   );

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard / reference model ----------------
   int n_vec = 0;
   int n_err = 0;
   int fd_seen = 0;

   logic [WIDTH-1:0] exp_q[$];              // samples captured so far in the current frame
   logic [WIDTH-1:0] m_bank [2][DEPTH];     // RAM image per bank
   bit               m_known [2][DEPTH];
   int               m_phase;               // 0 idle, 1 waiting, 2 capturing, 3 holding
   int               m_vcnt;
   int               m_auto;
   bit               m_prev_neg;
   bit               m_disp;
   bit               m_busy;
   bit               m_fd;
   bit               m_rd_known;
   logic [WIDTH-1:0] m_rd;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase    = 0;
      m_vcnt     = 0;
      m_auto     = 0;
      m_prev_neg = 1'b0;
      m_disp     = 1'b0;
      m_busy     = 1'b0;
      m_fd       = 1'b0;
      m_rd       = '0;
      m_rd_known = 1'b1;
      exp_q.delete();
   endtask

   task automatic model_capture(input logic [WIDTH-1:0] s, input int wb);
      m_bank[wb][exp_q.size()]  = s;
      m_known[wb][exp_q.size()] = 1'b1;
      exp_q.push_back(s);
   endtask

   // One rising edge worth of behaviour, using the inputs that were presented to it.
   task automatic model_step();
      int dec;
      int wb;
      bit dstb;
      bit crossing;
      logic [WIDTH-1:0] s;
      dec = (decim == '0) ? 1 : int'(decim);
      s   = sample_in;
      wb  = m_disp ? 0 : 1;
      if (int'(rd_addr) >= DEPTH) begin
         m_rd       = '0;
         m_rd_known = 1'b1;
      end else begin
         m_rd       = m_bank[m_disp][rd_addr];
         m_rd_known = m_known[m_disp][rd_addr];
      end
      dstb = 1'b0;
      if (sample_valid) begin
         dstb = ((m_vcnt % dec) == dec - 1);
         m_vcnt++;
      end
      m_fd = 1'b0;
      case (m_phase)
         0, 3: begin
            if (arm) begin
               m_phase = 1;
               m_auto  = 0;
            end
         end
         1: begin
            if (dstb) begin
               m_auto++;
               crossing = m_prev_neg && ($signed(s) >= 0);
               if (crossing || (AUTO_EN && m_auto == 4 * DEPTH)) begin
                  exp_q.delete();
                  model_capture(s, wb);
                  m_phase = 2;
               end
            end
         end
         default: begin
            if (dstb) begin
               model_capture(s, wb);
               if (exp_q.size() == DEPTH) begin
                  m_disp  = ~m_disp;
                  m_fd    = 1'b1;
                  m_phase = 3;
               end
            end
         end
      endcase
      if (dstb) m_prev_neg = ($signed(s) < 0);
      m_busy = (m_phase == 1) || (m_phase == 2);
   endtask

   task automatic compare();
      logic [1:0] ph;
      ph = m_phase[1:0];
      check_eq("busy", busy, m_busy);
      check_eq("frame_done", frame_done, m_fd);
      check_eq("disp_bank", disp_bank, m_disp);
      check_eq("state", dbg_state, ph);
      if (m_rd_known) check_eq("rd_data", rd_data, m_rd);
      if (frame_done) fd_seen++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clock);
      model_step();
      @(negedge clock);
      compare();
   endtask

   task automatic do_reset(input int d);
      resetn       = 1'b0;
      arm          = 1'b0;
      sample_valid = 1'b0;
      sample_in    = '0;
      rd_addr      = '0;
      decim        = DECIM_W'(d);
      @(negedge clock);
      @(negedge clock);
      model_reset();
      compare();
      resetn  = 1'b1;
      fd_seen = 0;
   endtask

   task automatic rand_addr();
      rd_addr = ADDR_W'($urandom_range(0, DEPTH + 40));
   endtask

   // ---------------- stimulus ----------------
   int fd_at;
   int toggles;
   bit last_disp;
   int k;

   initial begin
      // Ramp through zero, decim 1: trigger on the sample equal to 0.
      do_reset(1);
      arm = 1'b1;
      sample_valid = 1'b1;
      fd_at = -1;
      for (int i = 0; i < 800; i++) begin
         sample_in = WIDTH'(-100 + i);
         rand_addr();
         cycle();
         if (frame_done) fd_at = i;
      end
      check_eq("ramp_fd_count", fd_seen, 1);
      check_eq("ramp_fd_edge", fd_at, 739);
      rd_addr = ADDR_W'(5);
      cycle();
      check_eq("ramp_rd5", rd_data, 32'd5);

      // Decimate by 4: column k holds the trigger sample plus 4k.
      do_reset(4);
      arm = 1'b1;
      sample_valid = 1'b1;
      fd_at = -1;
      for (int i = 0; i < 2800; i++) begin
         sample_in = WIDTH'(-100 + i);
         rand_addr();
         cycle();
         if (frame_done) fd_at = i;
      end
      check_eq("dec4_fd_edge", fd_at, 2659);
      arm = 1'b0;
      for (int j = 0; j < 8; j++) begin
         k = $urandom_range(0, DEPTH - 1);
         rd_addr = ADDR_W'(k);
         cycle();
         check_eq("dec4_col", rd_data, 32'(3 + 4 * k));
      end

      // Constant positive level: no crossing, frame only if autotrigger is built in.
      do_reset(1);
      arm = 1'b1;
      sample_valid = 1'b1;
      sample_in = WIDTH'(200);
      for (int i = 0; i < 3400; i++) begin
         rand_addr();
         cycle();
      end
      check_eq("level_fd_count", fd_seen, AUTO_EN ? 32'd1 : 32'd0);

      // Sawtooth with arm held: two frames, display bank 0 -> 1 -> 0.
      do_reset(1);
      arm = 1'b1;
      sample_valid = 1'b1;
      toggles = 0;
      last_disp = 1'b0;
      for (int i = 0; i < 1700; i++) begin
         sample_in = WIDTH'((i % 256) - 128);
         if (i >= 880 && i < 1100) rd_addr = ADDR_W'(10);
         else rand_addr();
         if (i % 97 == 0) arm = 1'b0;
         else arm = 1'b1;
         cycle();
         if (disp_bank != last_disp) toggles++;
         last_disp = disp_bank;
         if (i == 1050) check_eq("bankA_stable", rd_data, 32'd10);
      end
      check_eq("saw_fd_count", fd_seen, 2);
      check_eq("saw_toggles", toggles, 2);

      // Asynchronous reset during the second capture.
      do_reset(1);
      arm = 1'b1;
      sample_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         sample_in = WIDTH'((i % 256) - 128);
         rand_addr();
         cycle();
      end
      check_eq("pre_reset_disp", disp_bank, 32'd1);
      #2 resetn = 1'b0;
      #1;
      check_eq("async_busy", busy, 32'd0);
      check_eq("async_disp", disp_bank, 32'd0);
      check_eq("async_rd", rd_data, 32'd0);
      check_eq("async_state", dbg_state, 32'd0);
      check_eq("async_fd", frame_done, 32'd0);
      model_reset();
      @(negedge clock);
      resetn = 1'b1;

      // Random valid, arm and decimation.
      for (int r = 0; r < 2; r++) begin
         do_reset($urandom_range(0, 3));
         for (int i = 0; i < 2500; i++) begin
            sample_valid = ($urandom_range(0, 9) < 7);
            arm = ($urandom_range(0, 9) == 0);
            sample_in = WIDTH'(((i * 7) % 512) - 256 + int'($urandom_range(0, 16)) - 8);
            rand_addr();
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
